// File: rtl/rs_multi_cdb_if.sv
// ---------------------------------------------------------------------------
// rs_multi_cdb_if
// Bundles the reservation-station traffic into one interface:
//   issue_*   : instruction and operands from decode/register-file issue
//   full_out  : no free station slot (issue must be gated upstream)
//   count_out : number of occupied slots
//   cdb_*     : NUM_CDB packed result buses, channel k at [k*W +: W]
//   ex_*      : valid/ready dispatch towards the execution unit
// master = issue stage / CDB producers / execution unit side
// slave  = reservation station
// ---------------------------------------------------------------------------
interface rs_multi_cdb_if #(
   parameter int ENTRY_W = 5,
   parameter int NUM_CDB = 2,
   parameter int CNT_W   = 5
);
   logic                       issue_valid;
   logic [5:0]                 issue_op;
   logic [31:0]                issue_pc;
   logic [31:0]                issue_imm;
   logic [ENTRY_W-1:0]         issue_entry;
   logic [31:0]                issue_vj;
   logic [31:0]                issue_vk;
   logic [ENTRY_W-1:0]         issue_qj;
   logic [ENTRY_W-1:0]         issue_qk;
   logic                       full_out;
   logic [CNT_W-1:0]           count_out;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*ENTRY_W-1:0] cdb_entry;
   logic [NUM_CDB*32-1:0]      cdb_value;
   logic                       ex_valid;
   logic                       ex_ready;
   logic [5:0]                 ex_op;
   logic [31:0]                ex_pc;
   logic [31:0]                ex_imm;
   logic [31:0]                ex_vj;
   logic [31:0]                ex_vk;
   logic [ENTRY_W-1:0]         ex_entry;

   modport master (
      output issue_valid, issue_op, issue_pc, issue_imm, issue_entry,
             issue_vj, issue_vk, issue_qj, issue_qk,
             cdb_valid, cdb_entry, cdb_value, ex_ready,
      input  full_out, count_out,
             ex_valid, ex_op, ex_pc, ex_imm, ex_vj, ex_vk, ex_entry
   );

   modport slave (
      input  issue_valid, issue_op, issue_pc, issue_imm, issue_entry,
             issue_vj, issue_vk, issue_qj, issue_qk,
             cdb_valid, cdb_entry, cdb_value, ex_ready,
      output full_out, count_out,
             ex_valid, ex_op, ex_pc, ex_imm, ex_vj, ex_vk, ex_entry
   );
endinterface

// File: rtl/rs_multi_cdb.sv
// ---------------------------------------------------------------------------
// rs_multi_cdb
// Reservation station for the Tomasulo core: holds up to RS_DEPTH instructions,
// snoops NUM_CDB result buses (with issue-time bypass), and dispatches the
// oldest ready instruction through a registered valid/ready output stage.
// Ports:
//   clk_in    : system clock
//   rst_in    : asynchronous active-low reset
//   rdy_in    : global ready, low freezes all state
//   roll_back : mispredict flush, empties the station and the output stage
//   bus       : issue / CDB / dispatch / occupancy signals (slave side)
// ---------------------------------------------------------------------------
module rs_multi_cdb #(
   parameter int RS_DEPTH = 16,
   parameter int ENTRY_W  = 5,
   parameter int NUM_CDB  = 2,
   parameter int CNT_W    = 5
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          roll_back,
   rs_multi_cdb_if.slave bus
);
   localparam int                 IDX_W      = $clog2(RS_DEPTH);
   localparam logic [ENTRY_W-1:0] ENTRY_NULL = {ENTRY_W{1'b1}};

   logic [RS_DEPTH-1:0] valid_q, valid_d;
   logic [5:0]          op_q    [RS_DEPTH];
   logic [31:0]         pc_q    [RS_DEPTH];
   logic [31:0]         imm_q   [RS_DEPTH];
   logic [31:0]         vj_q    [RS_DEPTH];
   logic [31:0]         vk_q    [RS_DEPTH];
   logic [ENTRY_W-1:0]  entry_q [RS_DEPTH];
   logic [ENTRY_W-1:0]  qj_q    [RS_DEPTH];
   logic [ENTRY_W-1:0]  qk_q    [RS_DEPTH];
   // older_q[i][j] = 1 when slot i was issued before slot j
   logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
   logic [CNT_W-1:0]    count_q, count_d;

   logic                ex_valid_q;
   logic [5:0]          ex_op_q;
   logic [31:0]         ex_pc_q, ex_imm_q, ex_vj_q, ex_vk_q;
   logic [ENTRY_W-1:0]  ex_entry_q;

   logic [RS_DEPTH-1:0] ready;
   logic [IDX_W-1:0]    free_idx, sel_idx;
   logic                have_free, have_sel, blocked;
   logic                issue_acc, disp_load, disp_fire;
   logic [32:0]         byp_j, byp_k;
   logic [32:0]         wake_j [RS_DEPTH];
   logic [32:0]         wake_k [RS_DEPTH];

   // Returns {hit, value}; lowest channel wins when several match.
   function automatic logic [32:0] cdb_match(
      input logic [ENTRY_W-1:0]         tag,
      input logic [NUM_CDB-1:0]         vld,
      input logic [NUM_CDB*ENTRY_W-1:0] tags,
      input logic [NUM_CDB*32-1:0]      vals
   );
      logic [32:0] res;
      res = '0;
      if (tag != ENTRY_NULL) begin
         for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (tags[k*ENTRY_W +: ENTRY_W] == tag)) res = {1'b1, vals[k*32 +: 32]};
         end
      end
      return res;
   endfunction

   // Lowest-index free slot.
   always_comb begin
      free_idx  = '0;
      have_free = 1'b0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx  = IDX_W'(i);
            have_free = 1'b1;
         end
      end
   end

   // Oldest ready slot: the one no other ready slot is older than.
   always_comb begin
      ready    = '0;
      sel_idx  = '0;
      have_sel = 1'b0;
      blocked  = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         ready[i] = valid_q[i] && (qj_q[i] == ENTRY_NULL) && (qk_q[i] == ENTRY_NULL);
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (ready[j] && older_q[j][i]) blocked = 1'b1;
         end
         if (ready[i] && !blocked) begin
            sel_idx  = IDX_W'(i);
            have_sel = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         wake_j[i] = cdb_match(qj_q[i], bus.cdb_valid, bus.cdb_entry, bus.cdb_value);
         wake_k[i] = cdb_match(qk_q[i], bus.cdb_valid, bus.cdb_entry, bus.cdb_value);
      end
   end

   assign byp_j     = cdb_match(bus.issue_qj, bus.cdb_valid, bus.cdb_entry, bus.cdb_value);
   assign byp_k     = cdb_match(bus.issue_qk, bus.cdb_valid, bus.cdb_entry, bus.cdb_value);
   assign issue_acc = rdy_in && !roll_back && bus.issue_valid && have_free;
   assign disp_load = rdy_in && !roll_back && (!ex_valid_q || bus.ex_ready);
   assign disp_fire = disp_load && have_sel;

   always_comb begin
      valid_d = valid_q;
      if (disp_fire) valid_d[sel_idx] = 1'b0;
      if (issue_acc) valid_d[free_idx] = 1'b1;
      count_d = count_q;
      if (issue_acc && !disp_fire)      count_d = count_q + CNT_W'(1);
      else if (!issue_acc && disp_fire) count_d = count_q - CNT_W'(1);
   end

   // Control state and the dispatch output register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q    <= '0;
         count_q    <= '0;
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_pc_q    <= '0;
         ex_imm_q   <= '0;
         ex_vj_q    <= '0;
         ex_vk_q    <= '0;
         ex_entry_q <= '0;
      end else if (rdy_in) begin
         if (roll_back) begin
            valid_q    <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            if (disp_load) begin
               ex_valid_q <= have_sel;
               if (have_sel) begin
                  ex_op_q    <= op_q[sel_idx];
                  ex_pc_q    <= pc_q[sel_idx];
                  ex_imm_q   <= imm_q[sel_idx];
                  ex_vj_q    <= vj_q[sel_idx];
                  ex_vk_q    <= vk_q[sel_idx];
                  ex_entry_q <= entry_q[sel_idx];
               end
            end
         end
      end
   end

   // Slot payload and age matrix; only meaningful where valid_q is set.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !roll_back) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && wake_j[i][32]) begin
               vj_q[i] <= wake_j[i][31:0];
               qj_q[i] <= ENTRY_NULL;
            end
            if (valid_q[i] && wake_k[i][32]) begin
               vk_q[i] <= wake_k[i][31:0];
               qk_q[i] <= ENTRY_NULL;
            end
         end
         if (issue_acc) begin
            op_q[free_idx]    <= bus.issue_op;
            pc_q[free_idx]    <= bus.issue_pc;
            imm_q[free_idx]   <= bus.issue_imm;
            entry_q[free_idx] <= bus.issue_entry;
            vj_q[free_idx]    <= byp_j[32] ? byp_j[31:0] : bus.issue_vj;
            qj_q[free_idx]    <= byp_j[32] ? ENTRY_NULL : bus.issue_qj;
            vk_q[free_idx]    <= byp_k[32] ? byp_k[31:0] : bus.issue_vk;
            qk_q[free_idx]    <= byp_k[32] ? ENTRY_NULL : bus.issue_qk;
            // New entry is younger than every other slot.
            older_q[free_idx] <= '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (j != int'(free_idx)) older_q[j][free_idx] <= 1'b1;
            end
         end
      end
   end

   assign bus.full_out  = &valid_q;
   assign bus.count_out = count_q;
   assign bus.ex_valid  = ex_valid_q;
   assign bus.ex_op     = ex_op_q;
   assign bus.ex_pc     = ex_pc_q;
   assign bus.ex_imm    = ex_imm_q;
   assign bus.ex_vj     = ex_vj_q;
   assign bus.ex_vk     = ex_vk_q;
   assign bus.ex_entry  = ex_entry_q;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// ---------------------------------------------------------------------------
// tb_rs_multi_cdb
// Directed stimulus against rs_multi_cdb. A queue-based model (entries kept in
// issue order) predicts dispatch, occupancy and full on every cycle; literal
// expectations pin key results of each scenario.
// ---------------------------------------------------------------------------
module tb_rs_multi_cdb;
   localparam int         DEPTH = 16;
   localparam int         EW    = 5;
   localparam int         NC    = 2;
   localparam int         CW    = 5;
   localparam logic [4:0] NULLT = 5'h1f;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [4:0]  ent;
      logic [4:0]  qj;
      logic [4:0]  qk;
   } ent_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b1;
   logic roll_back = 1'b0;

   rs_multi_cdb_if #(.ENTRY_W(EW), .NUM_CDB(NC), .CNT_W(CW)) bus ();

   rs_multi_cdb #(.RS_DEPTH(DEPTH), .ENTRY_W(EW), .NUM_CDB(NC), .CNT_W(CW)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .roll_back(roll_back),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   ent_t        mq[$];
   bit          m_ev = 1'b0;
   logic [5:0]  m_op = '0;
   logic [31:0] m_pc = '0, m_imm = '0, m_vj = '0, m_vk = '0;
   logic [4:0]  m_ent = '0;
   int          f;
   bit          was_full, hit;
   logic [31:0] hv;
   ent_t        e;

   task automatic lookup(input logic [4:0] tag, output bit h, output logic [31:0] v);
      h = 1'b0;
      v = '0;
      if (tag == NULLT) return;
      for (int k = 0; k < NC; k++) begin
         if (!h && bus.cdb_valid[k] && bus.cdb_entry[k*EW +: EW] == tag) begin
            h = 1'b1;
            v = bus.cdb_value[k*32 +: 32];
         end
      end
   endtask

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mq.delete();
         m_ev = 1'b0; m_op = '0; m_pc = '0; m_imm = '0; m_vj = '0; m_vk = '0; m_ent = '0;
      end else if (rdy_in) begin
         if (roll_back) begin
            mq.delete();
            m_ev = 1'b0;
         end else begin
            was_full = (mq.size() == DEPTH);
            if (!m_ev || bus.ex_ready) begin
               f = -1;
               for (int i = 0; i < mq.size(); i++)
                  if (f < 0 && mq[i].qj == NULLT && mq[i].qk == NULLT) f = i;
               m_ev = (f >= 0);
               if (f >= 0) begin
                  e = mq[f];
                  m_op = e.op; m_pc = e.pc; m_imm = e.imm; m_vj = e.vj; m_vk = e.vk; m_ent = e.ent;
                  mq.delete(f);
               end
            end
            for (int i = 0; i < mq.size(); i++) begin
               e = mq[i];
               lookup(e.qj, hit, hv);
               if (hit) begin e.vj = hv; e.qj = NULLT; end
               lookup(e.qk, hit, hv);
               if (hit) begin e.vk = hv; e.qk = NULLT; end
               mq[i] = e;
            end
            if (bus.issue_valid && !was_full) begin
               e.op = bus.issue_op; e.pc = bus.issue_pc; e.imm = bus.issue_imm;
               e.ent = bus.issue_entry; e.vj = bus.issue_vj; e.vk = bus.issue_vk;
               e.qj = bus.issue_qj; e.qk = bus.issue_qk;
               lookup(e.qj, hit, hv);
               if (hit) begin e.vj = hv; e.qj = NULLT; end
               lookup(e.qk, hit, hv);
               if (hit) begin e.vk = hv; e.qk = NULLT; end
               mq.push_back(e);
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk_in) begin
      if (cmp_on) begin
         chk("ex_valid", 64'(bus.ex_valid), 64'(m_ev));
         chk("count_out", 64'(bus.count_out), 64'(mq.size()));
         chk("full_out", 64'(bus.full_out), 64'(mq.size() == DEPTH));
         if (m_ev) begin
            chk("ex_op", 64'(bus.ex_op), 64'(m_op));
            chk("ex_pc", 64'(bus.ex_pc), 64'(m_pc));
            chk("ex_imm", 64'(bus.ex_imm), 64'(m_imm));
            chk("ex_vj", 64'(bus.ex_vj), 64'(m_vj));
            chk("ex_vk", 64'(bus.ex_vk), 64'(m_vk));
            chk("ex_entry", 64'(bus.ex_entry), 64'(m_ent));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      bus.issue_valid = 1'b0;
      bus.cdb_valid   = '0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      clear_inputs();
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] ent, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [4:0] qj, input logic [4:0] qk);
      bus.issue_valid = 1'b1;
      bus.issue_op    = op;
      bus.issue_pc    = pc;
      bus.issue_imm   = imm;
      bus.issue_entry = ent;
      bus.issue_vj    = vj;
      bus.issue_vk    = vk;
      bus.issue_qj    = qj;
      bus.issue_qk    = qk;
   endtask

   task automatic drive_cdb(input int k, input logic [4:0] tag, input logic [31:0] val);
      bus.cdb_valid[k]             = 1'b1;
      bus.cdb_entry[k*EW +: EW]    = tag;
      bus.cdb_value[k*32 +: 32]    = val;
   endtask

   initial begin
      bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_pc = '0; bus.issue_imm = '0;
      bus.issue_entry = '0; bus.issue_vj = '0; bus.issue_vk = '0;
      bus.issue_qj = NULLT; bus.issue_qk = NULLT;
      bus.cdb_valid = '0; bus.cdb_entry = '0; bus.cdb_value = '0;
      bus.ex_ready = 1'b1;

      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
      chk("rst_count", 64'(bus.count_out), 64'd0);
      chk("rst_ex_vj", 64'(bus.ex_vj), 64'd0);
      chk("rst_ex_entry", 64'(bus.ex_entry), 64'd0);
      rst_in = 1'b1;
      cmp_on = 1'b1;
      tick();

      // Ready issue: 1-cycle issue-to-dispatch
      issue(6'h01, 32'h100, 32'h0, 5'd3, 32'd5, 32'd7, NULLT, NULLT);
      tick();
      chk("ready_count1", 64'(bus.count_out), 64'd1);
      tick();
      chk("ready_ex_valid", 64'(bus.ex_valid), 64'd1);
      chk("ready_ex_vj", 64'(bus.ex_vj), 64'd5);
      chk("ready_ex_vk", 64'(bus.ex_vk), 64'd7);
      chk("ready_ex_entry", 64'(bus.ex_entry), 64'd3);
      chk("ready_count0", 64'(bus.count_out), 64'd0);
      tick();

      // Bypass on issue, then wakeup on channel 1
      issue(6'h02, 32'h104, 32'h0, 5'd8, 32'h0, 32'h0, 5'd4, 5'd6);
      drive_cdb(0, 5'd4, 32'h11);
      tick();
      drive_cdb(1, 5'd6, 32'h22);
      tick();
      chk("byp_not_yet", 64'(bus.ex_valid), 64'd0);
      tick();
      chk("byp_ex_valid", 64'(bus.ex_valid), 64'd1);
      chk("byp_ex_vj", 64'(bus.ex_vj), 64'h11);
      chk("byp_ex_vk", 64'(bus.ex_vk), 64'h22);
      chk("byp_ex_entry", 64'(bus.ex_entry), 64'd8);
      repeat (2) tick();

      // Age order B, A, C with slot reuse
      issue(6'h03, 32'h200, 32'h0, 5'd10, 32'h0, 32'hA, 5'd9, NULLT);
      tick();
      issue(6'h03, 32'h204, 32'h0, 5'd11, 32'hB, 32'hB, NULLT, NULLT);
      tick();
      tick();
      chk("age_B", 64'(bus.ex_entry), 64'd11);
      issue(6'h03, 32'h208, 32'h0, 5'd16, 32'hC, 32'hC, NULLT, NULLT);
      drive_cdb(0, 5'd9, 32'h99);
      tick();
      tick();
      chk("age_A", 64'(bus.ex_entry), 64'd10);
      chk("age_A_vj", 64'(bus.ex_vj), 64'h99);
      tick();
      chk("age_C", 64'(bus.ex_entry), 64'd16);
      repeat (2) tick();

      // Older entry in a higher slot goes before a younger one in slot 0
      issue(6'h04, 32'h300, 32'h0, 5'd12, 32'h1, 32'h1, NULLT, NULLT);
      tick();
      issue(6'h04, 32'h304, 32'h0, 5'd14, 32'h0, 32'h2, 5'd13, NULLT);
      tick();
      chk("age2_X", 64'(bus.ex_entry), 64'd12);
      issue(6'h04, 32'h308, 32'h0, 5'd15, 32'h3, 32'h3, NULLT, NULLT);
      drive_cdb(0, 5'd13, 32'h33);
      tick();
      tick();
      chk("age2_Y", 64'(bus.ex_entry), 64'd14);
      tick();
      chk("age2_Z", 64'(bus.ex_entry), 64'd15);
      repeat (2) tick();

      // Back-pressure until full
      bus.ex_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         issue(6'h05, 32'h400 + 32'(i), 32'h0, 5'(i), 32'd100 + 32'(i), 32'h0, NULLT, NULLT);
         tick();
      end
      chk("full_flag", 64'(bus.full_out), 64'd1);
      chk("full_count", 64'(bus.count_out), 64'(DEPTH));
      issue(6'h06, 32'h500, 32'h0, 5'd30, 32'h0, 32'h0, NULLT, NULLT);
      tick();
      chk("full_ignored", 64'(bus.count_out), 64'(DEPTH));
      chk("bp_hold_entry", 64'(bus.ex_entry), 64'd0);
      chk("bp_hold_vj", 64'(bus.ex_vj), 64'd100);
      bus.ex_ready = 1'b1;
      tick();
      chk("bp_first_disp", 64'(bus.ex_entry), 64'd1);
      chk("bp_not_full", 64'(bus.full_out), 64'd0);
      repeat (DEPTH + 2) tick();

      // Roll-back with 5 occupied slots and a coincident issue
      bus.ex_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         issue(6'h07, 32'h600, 32'h0, 5'(i), 32'(i), 32'h0, NULLT, NULLT);
         tick();
      end
      chk("rb_pre_count", 64'(bus.count_out), 64'd5);
      roll_back = 1'b1;
      issue(6'h07, 32'h640, 32'h0, 5'd7, 32'h7, 32'h0, NULLT, NULLT);
      tick();
      roll_back = 1'b0;
      chk("rb_count", 64'(bus.count_out), 64'd0);
      chk("rb_ex_valid", 64'(bus.ex_valid), 64'd0);
      bus.ex_ready = 1'b1;
      tick();

      // Stall: broadcast while rdy_in is low must be ignored
      issue(6'h08, 32'h700, 32'h0, 5'd21, 32'h0, 32'h7, 5'd20, NULLT);
      tick();
      rdy_in = 1'b0;
      drive_cdb(0, 5'd20, 32'h44);
      tick();
      drive_cdb(0, 5'd20, 32'h44);
      tick();
      chk("stall_count", 64'(bus.count_out), 64'd1);
      chk("stall_ex_valid", 64'(bus.ex_valid), 64'd0);
      rdy_in = 1'b1;
      tick();
      chk("stall_no_wake", 64'(bus.ex_valid), 64'd0);
      drive_cdb(1, 5'd20, 32'h55);
      tick();
      tick();
      chk("stall_disp", 64'(bus.ex_entry), 64'd21);
      chk("stall_vj", 64'(bus.ex_vj), 64'h55);
      repeat (2) tick();

      // Reset pulse mid-operation
      for (int i = 1; i <= 3; i++) begin
         issue(6'h09, 32'h800, 32'h0, 5'(i), 32'h0, 32'h0, 5'd25, NULLT);
         tick();
      end
      chk("mid_pre_count", 64'(bus.count_out), 64'd3);
      rst_in = 1'b0;
      #1;
      chk("mid_rst_ex_valid", 64'(bus.ex_valid), 64'd0);
      chk("mid_rst_count", 64'(bus.count_out), 64'd0);
      #1;
      rst_in = 1'b1;
      drive_cdb(0, 5'd25, 32'h66);
      tick();
      repeat (2) tick();
      chk("mid_no_disp", 64'(bus.ex_valid), 64'd0);

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised next-generation reservation station for the Tomasulo RISC-V core. It sits between decoder/register-file issue and the ALU. It holds up to RS_DEPTH instructions and snoops NUM_CDB result buses. Compared with the current station it adds issue-time CDB bypass, oldest-first selection, a valid/ready handshake towards the execution unit, and an occupancy count.

Parameters:
RS_DEPTH, 16, number of station slots (power of two, >=2)
ENTRY_W, 5, ROB tag width; tag value all-ones (ENTRY_NULL) means "operand ready"
NUM_CDB, 2, number of result buses snooped (channel 0 = ALU, 1 = LSB by convention)
CNT_W, 5, width of count_out, must be >= log2(RS_DEPTH)+1

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low = freeze all state
roll_back  input  1  mispredict flush
issue_valid  input  1  new instruction this cycle
issue_op  input  6  operation type
issue_pc  input  32  instruction PC
issue_imm  input  32  immediate
issue_entry  input  ENTRY_W  destination ROB tag
issue_vj / issue_vk  input  32 each  operand values
issue_qj / issue_qk  input  ENTRY_W each  operand producer tags, ENTRY_NULL = ready
full_out  output  1  no free slot (combinational from current state)
count_out  output  CNT_W  occupied slots (registered)
cdb_valid  input  NUM_CDB  per-channel broadcast strobe
cdb_entry  input  NUM_CDB*ENTRY_W  packed tags, channel k at [k*ENTRY_W +: ENTRY_W]
cdb_value  input  NUM_CDB*32  packed results, channel k at [k*32 +: 32]
ex_valid  output  1  dispatch valid
ex_ready  input  1  execution unit accepts
ex_op, ex_pc, ex_imm, ex_vj, ex_vk, ex_entry  output  6/32/32/32/32/ENTRY_W  dispatched payload

Behaviour:
- Reset (rst_in=0, async): all slots invalid, count_out=0, ex_valid=0, all ex_* payload=0.
- rdy_in=0: no state changes, including issue, CDB capture and dispatch. Outputs hold. Producers must not broadcast while rdy_in is low.
- roll_back=1 (with rdy_in=1): at the next edge, all slots invalid, count_out=0, ex_valid=0. Issue, wakeup and dispatch in that cycle are discarded. roll_back has priority over everything except reset.
- Issue: with issue_valid=1 and full_out=0, the lowest-index free slot is written. With full_out=1, issue is ignored; the upstream stage must gate on full_out.
- Issue bypass: if issue_qj (or issue_qk) equals cdb_entry[k] with cdb_valid[k]=1 in the same cycle, the slot stores Q=ENTRY_NULL and V=cdb_value[k].
- Wakeup: each valid slot with Qj (or Qk) matching an active channel takes that value and sets Q=ENTRY_NULL. If several channels match, the lowest channel index wins. Qj and Qk are matched independently, so both may wake in one cycle.
- Ready: a slot is dispatchable when it is valid and Qj=Qk=ENTRY_NULL, evaluated on registered state. A slot woken at edge t is dispatchable for the edge at t+1. An instruction issued with both operands ready at edge t can give ex_valid=1 after edge t+1, which is 1-cycle issue-to-dispatch latency.
- Selection: the oldest dispatchable slot in issue order, not in slot index order. Age tracking is via age matrix or equivalent. Ordering survives arbitrary slot reuse.
- Dispatch handshake: the output register loads when ex_valid=0 or (ex_valid=1 and ex_ready=1). If a dispatchable slot exists, payload is loaded, ex_valid=1 and the slot is freed at the same edge. Otherwise ex_valid=0. While ex_valid=1 and ex_ready=0, the payload is held stable and nothing dispatches.
- Freed slot: reusable from the next cycle.
- count_out: +1 on accepted issue, -1 on dispatch, unchanged if both happen in one edge. Never exceeds RS_DEPTH and never wraps.
- Illegal: issue with full_out=1 has no effect; assertion in the bench.

Test Plan:
- Reset mid-operation: 3 slots filled, rst_in pulsed low between edges -> ex_valid=0 and count_out=0 immediately; no dispatch after release.
- Ready issue: op=ADD, vj=5, vk=7, qj=qk=ENTRY_NULL, entry=3 at edge 0, ex_ready=1 -> ex_valid=1, ex_vj=5, ex_vk=7, ex_entry=3 after edge 1; count_out back to 0 after edge 1.
- Bypass plus dual wakeup: issue qj=4, qk=6 while cdb0 broadcasts (4, 0x11) -> Vj=0x11 stored. Next cycle cdb1 broadcasts (6, 0x22) -> dispatch with vj=0x11, vk=0x22 one cycle later.
- Age order: issue A (waits on tag 9) into slot 0, then ready B into slot 1, then ready C into the slot freed by B, then wake A -> dispatch order B, A, C after slot reuse.
- Back-pressure and full: fill RS_DEPTH slots with ex_ready=0 -> full_out=1, count_out=RS_DEPTH, extra issue ignored, ex_* stable. Raise ex_ready -> one dispatch per cycle, full_out=0 the cycle after the first dispatch.
- Rollback and stall: roll_back with 5 occupied slots and a coincident issue -> count_out=0, ex_valid=0. With rdy_in=0 during a CDB broadcast -> no wakeup and no dispatch; state identical after rdy_in returns.
